// File: rtl/tti_rx_desc_packer.sv
// TTI RX back end: packs received private-write bytes little-endian into RX data
// words and emits one RX descriptor per transfer once all of its words are written.
module tti_rx_desc_packer #(
  parameter int unsigned TtiRxDataWidth     = 32,
  parameter int unsigned TtiRxDescDataWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          transfer_start_i,
  input  logic                          transfer_stop_i,
  input  logic [7:0]                    bus_addr_i,
  input  logic                          bus_addr_valid_i,
  input  logic                          rx_byte_valid_i,
  input  logic [7:0]                    rx_byte_i,
  output logic                          rx_byte_ready_o,
  output logic                          rx_queue_wvalid_o,
  input  logic                          rx_queue_wready_i,
  output logic [TtiRxDataWidth-1:0]     rx_queue_wdata_o,
  output logic                          rx_desc_queue_wvalid_o,
  input  logic                          rx_desc_queue_wready_i,
  output logic [TtiRxDescDataWidth-1:0] rx_desc_queue_wdata_o,
  output logic                          err_len_ovf_o,
  output logic                          busy_o
);

  localparam int unsigned NumLanes = TtiRxDataWidth / 8;
  localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NumLanes - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COLLECT,
    S_DRAIN,
    S_DESC
  } state_e;

  state_e                    state_q, state_d;
  logic [6:0]                addr_q, addr_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [LaneW-1:0]          lane_q, lane_d;
  logic                      err_q, err_d;
  logic                      ovf_q, ovf_d;
  logic                      rstart_q, rstart_d;
  logic                      wvalid_q, wvalid_d;
  logic [TtiRxDataWidth-1:0] wdata_q, wdata_d;

  logic byte_acc;
  logic end_evt;

  assign rx_byte_ready_o = ((state_q == S_COLLECT) && !wvalid_q) ||
                           (state_q == S_IDLE) || (state_q == S_ADDR);
  assign byte_acc = rx_byte_valid_i && rx_byte_ready_o;
  assign end_evt  = transfer_start_i || transfer_stop_i;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    err_d    = err_q;
    ovf_d    = 1'b0;
    rstart_d = rstart_q;
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;

    // A consumed word clears the buffer so unused lanes of the next partial word read zero.
    if (wvalid_q && rx_queue_wready_i) begin
      wvalid_d = 1'b0;
      wdata_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable_i && transfer_start_i) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (!enable_i || transfer_stop_i) begin
          state_d = S_IDLE;
        end else if (bus_addr_valid_i) begin
          if (bus_addr_i[0]) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = bus_addr_i[7:1];
            cnt_d   = '0;
            lane_d  = '0;
            err_d   = 1'b0;
            wdata_d = '0;
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (!enable_i) begin
          // A pending word must still be handshaken before abandoning the transfer.
          if (!wvalid_q) begin
            lane_d  = '0;
            wdata_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          if (byte_acc) begin
            if (cnt_q == 16'hFFFF) begin
              err_d = 1'b1;
              ovf_d = !err_q;
            end else begin
              for (int unsigned l = 0; l < NumLanes; l++) begin
                if (lane_q == LaneW'(l)) begin
                  wdata_d[l*8 +: 8] = rx_byte_i;
                end
              end
              cnt_d = cnt_q + 16'd1;
              if (lane_q == LastLane) begin
                wvalid_d = 1'b1;
                lane_d   = '0;
              end else begin
                lane_d = lane_q + LaneW'(1);
              end
            end
          end
          // End event is processed after the same-cycle byte so a partial word is flushed.
          if (end_evt) begin
            if (lane_d != '0) begin
              wvalid_d = 1'b1;
              lane_d   = '0;
            end
            rstart_d = transfer_start_i && !transfer_stop_i;
            state_d  = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (!wvalid_q) begin
          state_d = S_DESC;
        end
      end

      S_DESC: begin
        if (rx_desc_queue_wready_i) begin
          state_d = rstart_q ? S_ADDR : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rstart_q <= 1'b0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      rstart_q <= rstart_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rx_queue_wvalid_o      = wvalid_q;
  assign rx_queue_wdata_o       = wdata_q;
  assign rx_desc_queue_wvalid_o = (state_q == S_DESC);
  assign rx_desc_queue_wdata_o  = {err_q, 8'h00, addr_q, cnt_q};
  assign err_len_ovf_o          = ovf_q;
  assign busy_o                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_tti_rx_desc_packer.sv
// Directed bench for tti_rx_desc_packer with N=4 lanes.
module tb_tti_rx_desc_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        tstart;
  logic        tstop;
  logic [7:0]  bus_addr;
  logic        bus_addr_valid;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        dvalid;
  logic        dready;
  logic [31:0] ddata;
  logic        ovf;
  logic        busy;

  always #5 clk = ~clk;

  tti_rx_desc_packer #(
    .TtiRxDataWidth    (32),
    .TtiRxDescDataWidth(32)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .enable_i              (enable),
    .transfer_start_i      (tstart),
    .transfer_stop_i       (tstop),
    .bus_addr_i            (bus_addr),
    .bus_addr_valid_i      (bus_addr_valid),
    .rx_byte_valid_i       (byte_valid),
    .rx_byte_i             (byte_data),
    .rx_byte_ready_o       (byte_ready),
    .rx_queue_wvalid_o     (wvalid),
    .rx_queue_wready_i     (wready),
    .rx_queue_wdata_o      (wdata),
    .rx_desc_queue_wvalid_o(dvalid),
    .rx_desc_queue_wready_i(dready),
    .rx_desc_queue_wdata_o (ddata),
    .err_len_ovf_o         (ovf),
    .busy_o                (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] data_q[$];
  int          data_cyc[$];
  logic [31:0] desc_q[$];
  int          desc_rise[$];
  int          ovf_cnt = 0;
  logic        dvalid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (wvalid && wready) begin
      data_q.push_back(wdata);
      data_cyc.push_back(cyc);
    end
    if (dvalid && dready) desc_q.push_back(ddata);
    if (dvalid && !dvalid_prev) desc_rise.push_back(cyc);
    dvalid_prev = dvalid;
    if (ovf) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    if (!acc) check("byte_accept_timeout", 32'(acc), 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic start_addr(input logic [6:0] a, input logic rnw);
    tstart = 1'b1;
    tick();
    tstart         = 1'b0;
    bus_addr       = {a, rnw};
    bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
  endtask

  task automatic do_stop();
    tstop = 1'b1;
    tick();
    tstop = 1'b0;
  endtask

  task automatic wait_desc(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dvalid && dready) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!seen) check(tag, 32'(seen), 32'd1);
  endtask

  int nd, ns, no;

  initial begin
    rst_n = 1'b0; enable = 1'b1; tstart = 1'b0; tstop = 1'b0;
    bus_addr = '0; bus_addr_valid = 1'b0; byte_valid = 1'b0; byte_data = '0;
    wready = 1'b1; dready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_ddata", ddata, 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic write: 6 bytes -> two words and a descriptor
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h5A, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    @(negedge clk);
    check("full_word_wvalid", 32'(wvalid), 32'd1);
    check("full_word_bubble", 32'(byte_ready), 32'd0);
    check("full_word_data", wdata, 32'h04030201);
    tick();
    send_byte(8'h05);
    send_byte(8'h06);
    do_stop();
    wait_desc("t1_desc_timeout");
    @(negedge clk);
    check("t1_busy_idle", 32'(busy), 32'd0);
    check("t1_nwords", 32'(data_q.size() - nd), 32'd2);
    check("t1_word0", data_q[nd], 32'h04030201);
    check("t1_word1", data_q[nd+1], 32'h00000605);
    check("t1_ndesc", 32'(desc_q.size() - ns), 32'd1);
    check("t1_desc", desc_q[ns], 32'h005A0006);
    tick();

    // Zero-byte write, STOP timing and descriptor backpressure
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h11, 1'b0);
    dready = 1'b0;
    do_stop();
    @(negedge clk);
    check("zb_dvalid_t1", 32'(dvalid), 32'd0);
    check("zb_busy_drain", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("zb_dvalid_t2", 32'(dvalid), 32'd1);
    check("zb_ddata", ddata, 32'h00110000);
    repeat (3) tick();
    @(negedge clk);
    check("zb_dvalid_hold", 32'(dvalid), 32'd1);
    check("zb_ddata_hold", ddata, 32'h00110000);
    tick();
    dready = 1'b1;
    wait_desc("zb_desc_timeout");
    check("zb_nwords", 32'(data_q.size() - nd), 32'd0);
    check("zb_desc", desc_q[ns], 32'h00110000);

    // Read transfer: bytes discarded, nothing emitted
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h5A, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    do_stop();
    repeat (3) tick();
    @(negedge clk);
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_nwords", 32'(data_q.size() - nd), 32'd0);
    check("rd_ndesc", 32'(desc_q.size() - ns), 32'd0);
    tick();

    // Data queue backpressure on the first word
    nd = data_q.size(); ns = desc_q.size();
    wready = 1'b0;
    start_addr(7'h5A, 1'b0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    byte_valid = 1'b1;
    byte_data  = 8'h05;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_byte_ready", 32'(byte_ready), 32'd0);
      check("bp_wvalid", 32'(wvalid), 32'd1);
      check("bp_wdata", wdata, 32'h04030201);
      tick();
    end
    wready = 1'b1;
    send_byte(8'h05);
    send_byte(8'h06);
    do_stop();
    wait_desc("bp_desc_timeout");
    check("bp_nwords", 32'(data_q.size() - nd), 32'd2);
    check("bp_word0", data_q[nd], 32'h04030201);
    check("bp_word1", data_q[nd+1], 32'h00000605);
    check("bp_desc", desc_q[ns], 32'h005A0006);
    check("bp_order", 32'(desc_rise[desc_rise.size()-1] > data_cyc[nd+1]), 32'd1);

    // Repeated START splits into two transfers
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h5A, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    tstart = 1'b1;
    tick();
    tstart = 1'b0;
    wait_desc("rs_desc0_timeout");
    bus_addr       = {7'h22, 1'b0};
    bus_addr_valid = 1'b1;
    tick();
    bus_addr_valid = 1'b0;
    send_byte(8'hAA);
    do_stop();
    wait_desc("rs_desc1_timeout");
    check("rs_nwords", 32'(data_q.size() - nd), 32'd2);
    check("rs_word0", data_q[nd], 32'h00000201);
    check("rs_word1", data_q[nd+1], 32'h000000AA);
    check("rs_ndesc", 32'(desc_q.size() - ns), 32'd2);
    check("rs_desc0", desc_q[ns], 32'h005A0002);
    check("rs_desc1", desc_q[ns+1], 32'h00220001);
    check("rs_order0", 32'(desc_rise[desc_rise.size()-2] > data_cyc[nd]), 32'd1);
    check("rs_order1", 32'(desc_rise[desc_rise.size()-1] > data_cyc[nd+1]), 32'd1);

    // Enable dropped mid-collect abandons the transfer
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h44, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    enable = 1'b0;
    tick();
    @(negedge clk);
    check("en_busy", 32'(busy), 32'd0);
    tick();
    enable = 1'b1;
    repeat (4) tick();
    check("en_nwords", 32'(data_q.size() - nd), 32'd0);
    check("en_ndesc", 32'(desc_q.size() - ns), 32'd0);

    // Reset mid-collect with 2 bytes buffered
    nd = data_q.size(); ns = desc_q.size();
    start_addr(7'h33, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_byte_ready", 32'(byte_ready), 32'd1);
    check("mr_wvalid", 32'(wvalid), 32'd0);
    check("mr_wdata", wdata, 32'h0);
    check("mr_dvalid", 32'(dvalid), 32'd0);
    check("mr_ddata", ddata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    start_addr(7'h33, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h09 - 8'(i));
    do_stop();
    wait_desc("mr_desc_timeout");
    check("mr_nwords", 32'(data_q.size() - nd), 32'd1);
    check("mr_word0", data_q[nd], 32'h06070809);
    check("mr_desc", desc_q[ns], 32'h00330004);

    // 65537 bytes: count saturates, error bit set, single overflow pulse
    nd = data_q.size(); ns = desc_q.size(); no = ovf_cnt;
    start_addr(7'h7F, 1'b0);
    for (int i = 0; i < 65537; i++) send_byte(8'(i));
    do_stop();
    wait_desc("ovf_desc_timeout");
    check("ovf_nwords", 32'(data_q.size() - nd), 32'd16384);
    check("ovf_first_word", data_q[nd], 32'h03020100);
    check("ovf_last_word", data_q[data_q.size()-1], 32'h00FEFDFC);
    check("ovf_desc", desc_q[ns], 32'h807FFFFF);
    check("ovf_pulses", 32'(ovf_cnt - no), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
